// File: rtl/adc_acq_pkg.sv
// Shared encodings for the ADC acquisition sequencer: FSM states,
// trigger source codes and trigger edge codes.
package adc_acq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] SRC_SW  = 2'd0;
    localparam logic [1:0] SRC_CHA = 2'd1;
    localparam logic [1:0] SRC_CHB = 2'd2;
    localparam logic [1:0] SRC_EXT = 2'd3;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_FILL) || (st == ST_ARMED) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/adc_trig_detect.sv
// Level-crossing trigger with hysteresis on one signed sample stream.
// The flag arms once the signal has been clearly on the far side of the level.
module adc_trig_detect
    import adc_acq_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_strobe,
    input  logic [DATA_W-1:0] i_level,
    input  logic [DATA_W-1:0] i_hyst,
    input  logic              i_edge,
    input  logic              i_clear,
    output logic              o_fire
);

    localparam int CW = DATA_W + 2;

    logic signed [CW-1:0] w_sample;
    logic signed [CW-1:0] w_level;
    logic signed [CW-1:0] w_hyst;
    logic signed [CW-1:0] w_lo;
    logic signed [CW-1:0] w_hi;
    logic                 w_set;
    logic                 w_hit;
    logic                 r_flag;

    // Two guard bits keep level +/- hyst exact without saturation.
    assign w_sample = {{2{i_sample[DATA_W-1]}}, i_sample};
    assign w_level  = {{2{i_level[DATA_W-1]}}, i_level};
    assign w_hyst   = {2'b00, i_hyst};
    assign w_lo     = w_level - w_hyst;
    assign w_hi     = w_level + w_hyst;

    always_comb begin
        w_set = 1'b0;
        w_hit = 1'b0;
        if (i_edge == EDGE_FALL) begin
            w_set = (w_sample > w_hi);
            w_hit = (w_sample <= w_level);
        end else begin
            w_set = (w_sample < w_lo);
            w_hit = (w_sample >= w_level);
        end
    end

    assign o_fire = i_strobe && r_flag && w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
        end else if (i_clear) begin
            r_flag <= 1'b0;
        end else if (i_strobe) begin
            if (o_fire) begin
                r_flag <= 1'b0;
            end else if (w_set) begin
                r_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_acq_ctrl.sv
// Trigger/acquisition sequencer: decimates ADC samples and writes a circular
// capture buffer holding a pretrigger and posttrigger window around a trigger.
module adc_acq_ctrl
    import adc_acq_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 14,
    parameter int DEC_W  = 16
) (
    input  logic                  adc_clk,
    input  logic                  adc_rst_i,
    input  logic [DATA_W-1:0]     adc_dat_a_i,
    input  logic [DATA_W-1:0]     adc_dat_b_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic                  sw_trig_i,
    input  logic                  ext_trig_i,
    input  logic [1:0]            trig_src_i,
    input  logic                  trig_edge_i,
    input  logic [DATA_W-1:0]     trig_level_i,
    input  logic [DATA_W-1:0]     trig_hyst_i,
    input  logic [ADDR_W-1:0]     pretrig_i,
    input  logic [ADDR_W-1:0]     posttrig_i,
    input  logic [DEC_W-1:0]      decim_i,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [2*DATA_W-1:0]   wr_dat_o,
    output logic [ADDR_W-1:0]     trig_addr_o,
    output logic                  trig_o,
    output logic [2:0]            state_o,
    output logic                  busy_o,
    output logic                  done_o
);

    logic [2:0]          r_state;
    logic [1:0]          r_src;
    logic                r_edge;
    logic [DATA_W-1:0]   r_level;
    logic [DATA_W-1:0]   r_hyst;
    logic [ADDR_W-1:0]   r_pre;
    logic [ADDR_W-1:0]   r_post;
    logic [DEC_W-1:0]    r_decim;
    logic [DEC_W-1:0]    r_dec_cnt;
    logic [DATA_W-1:0]   r_s1_a;
    logic [DATA_W-1:0]   r_s1_b;
    logic                r_ext_d;
    logic                r_pend;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [2*DATA_W-1:0] r_wr_dat;
    logic                r_trig;
    logic [ADDR_W-1:0]   r_trig_addr;

    logic                w_strobe;
    logic                w_go;
    logic                w_busy;
    logic                w_armed;
    logic                w_write;
    logic                w_lvl_src;
    logic [DATA_W-1:0]   w_lvl_sample;
    logic                w_lvl_fire;
    logic                w_ext_rise;
    logic                w_evt;
    logic                w_trig_hit;
    logic [ADDR_W:0]     w_cnt_inc;
    logic                w_pre_last;
    logic                w_post_last;

    assign w_strobe     = (r_dec_cnt == '0);
    assign w_go         = !arm_i && !abort_i;
    assign w_busy       = is_busy(r_state);
    assign w_armed      = (r_state == ST_ARMED);
    assign w_write      = w_busy && w_strobe && w_go;
    assign w_lvl_src    = (r_src == SRC_CHA) || (r_src == SRC_CHB);
    assign w_lvl_sample = (r_src == SRC_CHB) ? r_s1_b : r_s1_a;
    assign w_ext_rise   = ext_trig_i && !r_ext_d;
    assign w_evt        = ((r_src == SRC_SW) && sw_trig_i) || ((r_src == SRC_EXT) && w_ext_rise);
    assign w_trig_hit   = w_armed && w_write && (w_lvl_src ? w_lvl_fire : (r_pend || w_evt));
    assign w_cnt_inc    = {1'b0, r_cnt} + (ADDR_W+1)'(1);
    assign w_pre_last   = (w_cnt_inc == {1'b0, r_pre});
    assign w_post_last  = (w_cnt_inc == {1'b0, r_post});

    adc_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .clk      (adc_clk),
        .rst_n    (adc_rst_i),
        .i_sample (w_lvl_sample),
        .i_strobe (w_write && w_armed && w_lvl_src),
        .i_level  (r_level),
        .i_hyst   (r_hyst),
        .i_edge   (r_edge),
        .i_clear  (!w_go),
        .o_fire   (w_lvl_fire)
    );

    always_ff @(posedge adc_clk or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_ext_d <= 1'b0;
        end else begin
            r_s1_a  <= adc_dat_a_i;
            r_s1_b  <= adc_dat_b_i;
            r_ext_d <= ext_trig_i;
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            r_dec_cnt <= '0;
        end else if (arm_i) begin
            r_dec_cnt <= decim_i;
        end else if (w_strobe) begin
            r_dec_cnt <= r_decim;
        end else begin
            r_dec_cnt <= r_dec_cnt - DEC_W'(1);
        end
    end

    // An sw/ext event between strobes is held so it lands on the next strobed sample.
    always_ff @(posedge adc_clk or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            r_pend <= 1'b0;
        end else if (!w_go || !w_armed || w_trig_hit) begin
            r_pend <= 1'b0;
        end else if (w_evt) begin
            r_pend <= 1'b1;
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            r_state     <= ST_IDLE;
            r_src       <= SRC_SW;
            r_edge      <= EDGE_RISE;
            r_level     <= '0;
            r_hyst      <= '0;
            r_pre       <= '0;
            r_post      <= '0;
            r_decim     <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_dat    <= '0;
            r_trig      <= 1'b0;
            r_trig_addr <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_trig  <= 1'b0;
            if (abort_i) begin
                r_state <= ST_IDLE;
            end else if (arm_i) begin
                r_state     <= (pretrig_i == '0) ? ST_ARMED : ST_FILL;
                r_src       <= trig_src_i;
                r_edge      <= trig_edge_i;
                r_level     <= trig_level_i;
                r_hyst      <= trig_hyst_i;
                r_pre       <= pretrig_i;
                r_post      <= posttrig_i;
                r_decim     <= decim_i;
                r_addr      <= '0;
                r_cnt       <= '0;
                r_trig_addr <= '0;
            end else if (w_write) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_dat  <= {r_s1_b, r_s1_a};
                r_addr    <= r_addr + ADDR_W'(1);
                case (r_state)
                    ST_FILL: begin
                        if (w_pre_last) begin
                            r_state <= ST_ARMED;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc[ADDR_W-1:0];
                        end
                    end
                    ST_ARMED: begin
                        if (w_trig_hit) begin
                            r_trig      <= 1'b1;
                            r_trig_addr <= r_addr;
                            r_cnt       <= '0;
                            r_state     <= (r_post == '0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (w_post_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= w_cnt_inc[ADDR_W-1:0];
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_dat_o    = r_wr_dat;
    assign trig_addr_o = r_trig_addr;
    assign trig_o      = r_trig;
    assign state_o     = r_state;
    assign busy_o      = w_busy;
    assign done_o      = (r_state == ST_DONE);

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Directed bench for adc_acq_ctrl with a 16-entry buffer so address wrap is easy to reach.
module tb_adc_acq_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 14;
    localparam int DEC_W  = 16;

    logic                  adc_clk = 1'b0;
    logic                  adc_rst_i = 1'b0;
    logic [DATA_W-1:0]     adc_dat_a_i = '0;
    logic [DATA_W-1:0]     adc_dat_b_i = '0;
    logic                  arm_i = 1'b0;
    logic                  abort_i = 1'b0;
    logic                  sw_trig_i = 1'b0;
    logic                  ext_trig_i = 1'b0;
    logic [1:0]            trig_src_i = '0;
    logic                  trig_edge_i = 1'b0;
    logic [DATA_W-1:0]     trig_level_i = '0;
    logic [DATA_W-1:0]     trig_hyst_i = '0;
    logic [ADDR_W-1:0]     pretrig_i = '0;
    logic [ADDR_W-1:0]     posttrig_i = '0;
    logic [DEC_W-1:0]      decim_i = '0;
    logic                  wr_en_o;
    logic [ADDR_W-1:0]     wr_addr_o;
    logic [2*DATA_W-1:0]   wr_dat_o;
    logic [ADDR_W-1:0]     trig_addr_o;
    logic                  trig_o;
    logic [2:0]            state_o;
    logic                  busy_o;
    logic                  done_o;

    adc_acq_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEC_W  (DEC_W)
    ) dut (
        .adc_clk      (adc_clk),
        .adc_rst_i    (adc_rst_i),
        .adc_dat_a_i  (adc_dat_a_i),
        .adc_dat_b_i  (adc_dat_b_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .sw_trig_i    (sw_trig_i),
        .ext_trig_i   (ext_trig_i),
        .trig_src_i   (trig_src_i),
        .trig_edge_i  (trig_edge_i),
        .trig_level_i (trig_level_i),
        .trig_hyst_i  (trig_hyst_i),
        .pretrig_i    (pretrig_i),
        .posttrig_i   (posttrig_i),
        .decim_i      (decim_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_dat_o     (wr_dat_o),
        .trig_addr_o  (trig_addr_o),
        .trig_o       (trig_o),
        .state_o      (state_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 adc_clk = ~adc_clk;

    int errors = 0;
    int checks = 0;
    int cycleCnt = 0;
    int armCycle = 0;
    int nWrites = 0;
    int trigCount = 0;
    int trigIdx = -1;
    int nBefore = 0;
    int wrAddrLog [64];
    int wrChaLog  [64];
    int wrChbLog  [64];
    int wrCycleLog[64];
    int t2Samples [20];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearLog();
        nWrites   = 0;
        trigCount = 0;
        trigIdx   = -1;
    endtask

    task automatic setConfig(input int src, input int edgeSel, input int level, input int hyst,
                             input int pre, input int post, input int decim);
        trig_src_i   = 2'(src);
        trig_edge_i  = 1'(edgeSel);
        trig_level_i = DATA_W'(level);
        trig_hyst_i  = DATA_W'(hyst);
        pretrig_i    = ADDR_W'(pre);
        posttrig_i   = ADDR_W'(post);
        decim_i      = DEC_W'(decim);
    endtask

    // Presents one CHA/CHB sample pair for one clock, clears pulses, logs any write.
    task automatic applyStimulus(input int a, input int b);
        logic signed [DATA_W-1:0] tA;
        logic signed [DATA_W-1:0] tB;
        adc_dat_a_i = DATA_W'(a);
        adc_dat_b_i = DATA_W'(b);
        @(posedge adc_clk);
        #1;
        cycleCnt++;
        arm_i     = 1'b0;
        abort_i   = 1'b0;
        sw_trig_i = 1'b0;
        if (wr_en_o) begin
            if (nWrites < 64) begin
                tA = wr_dat_o[DATA_W-1:0];
                tB = wr_dat_o[2*DATA_W-1:DATA_W];
                wrAddrLog[nWrites]  = int'(wr_addr_o);
                wrChaLog[nWrites]   = int'(tA);
                wrChbLog[nWrites]   = int'(tB);
                wrCycleLog[nWrites] = cycleCnt;
            end
            nWrites++;
        end
        if (trig_o) begin
            trigCount++;
            trigIdx = nWrites - 1;
        end
    endtask

    initial begin
        repeat (3) @(posedge adc_clk);
        #1;
        checkOutput("rst_wr_en", int'(wr_en_o), 0);
        checkOutput("rst_state", int'(state_o), 0);
        checkOutput("rst_busy", int'(busy_o), 0);
        checkOutput("rst_done", int'(done_o), 0);
        checkOutput("rst_trig", int'(trig_o), 0);
        checkOutput("rst_wr_dat", int'(wr_dat_o), 0);
        adc_rst_i = 1'b1;
        applyStimulus(0, 0);

        $display("[TB] test1: CHA rising ramp, pre=4 post=3");
        setConfig(1, 0, 0, 100, 4, 3, 0);
        clearLog();
        arm_i = 1'b1;
        applyStimulus(-500, 123);
        armCycle = cycleCnt;
        checkOutput("t1_state_fill", int'(state_o), 1);
        for (int k = 1; k < 20; k++) begin
            applyStimulus(-500 + 50 * k, 123);
            if (k == 4) checkOutput("t1_state_armed", int'(state_o), 2);
        end
        checkOutput("t1_first_lat", wrCycleLog[0] - armCycle, 1);
        checkOutput("t1_first_dat", wrChaLog[0], -500);
        checkOutput("t1_addr3", wrAddrLog[3], 3);
        checkOutput("t1_writes", nWrites, 14);
        checkOutput("t1_trig_cnt", trigCount, 1);
        checkOutput("t1_trig_idx", trigIdx, 10);
        checkOutput("t1_trig_dat", wrChaLog[10], 0);
        checkOutput("t1_trig_addr", int'(trig_addr_o), 10);
        checkOutput("t1_last_cha", wrChaLog[13], 150);
        checkOutput("t1_last_chb", wrChbLog[13], 123);
        checkOutput("t1_done", int'(done_o), 1);
        checkOutput("t1_state_done", int'(state_o), 4);
        checkOutput("t1_busy", int'(busy_o), 0);
        checkOutput("t1_wr_idle", int'(wr_en_o), 0);

        $display("[TB] test2: hysteresis not met, then met");
        for (int i = 0; i < 20; i++) t2Samples[i] = (i < 12 && (i % 2) == 0) ? -50 : 10;
        t2Samples[12] = -150;
        setConfig(1, 0, 0, 100, 2, 2, 0);
        clearLog();
        arm_i = 1'b1;
        applyStimulus(t2Samples[0], 0);
        for (int k = 1; k < 20; k++) applyStimulus(t2Samples[k], 0);
        checkOutput("t2_trig_cnt", trigCount, 1);
        checkOutput("t2_trig_idx", trigIdx, 13);
        checkOutput("t2_arm_dat", wrChaLog[12], -150);
        checkOutput("t2_trig_dat", wrChaLog[13], 10);
        checkOutput("t2_trig_addr", int'(trig_addr_o), 13);
        checkOutput("t2_writes", nWrites, 16);
        checkOutput("t2_done", int'(done_o), 1);

        $display("[TB] test3: address wrap, sw trigger on 20th strobe");
        setConfig(0, 0, 0, 0, 2, 3, 0);
        clearLog();
        arm_i = 1'b1;
        applyStimulus(0, 0);
        for (int k = 1; k < 30; k++) begin
            if (k == 1 || k == 20) sw_trig_i = 1'b1;
            applyStimulus(k, -k);
        end
        checkOutput("t3_writes", nWrites, 23);
        checkOutput("t3_trig_cnt", trigCount, 1);
        checkOutput("t3_trig_idx", trigIdx, 19);
        checkOutput("t3_addr15", wrAddrLog[15], 15);
        checkOutput("t3_wrap0", wrAddrLog[16], 0);
        checkOutput("t3_trig_wr_addr", wrAddrLog[19], 3);
        checkOutput("t3_trig_addr", int'(trig_addr_o), 3);
        checkOutput("t3_trig_cha", wrChaLog[19], 19);
        checkOutput("t3_trig_chb", wrChbLog[19], -19);
        checkOutput("t3_last_addr", wrAddrLog[22], 6);

        $display("[TB] test4: decimation by 3");
        setConfig(0, 0, 0, 0, 1, 1, 2);
        clearLog();
        arm_i = 1'b1;
        applyStimulus(100, 0);
        armCycle = cycleCnt;
        for (int k = 1; k <= 12; k++) applyStimulus(100 + k, 0);
        checkOutput("t4_first_lat", wrCycleLog[0] - armCycle, 3);
        checkOutput("t4_gap1", wrCycleLog[1] - wrCycleLog[0], 3);
        checkOutput("t4_gap2", wrCycleLog[2] - wrCycleLog[1], 3);
        checkOutput("t4_dat0", wrChaLog[0], 102);
        checkOutput("t4_dat1", wrChaLog[1], 105);
        checkOutput("t4_writes", nWrites, 4);
        checkOutput("t4_state_armed", int'(state_o), 2);
        abort_i = 1'b1;
        applyStimulus(0, 0);
        checkOutput("t4_abort_state", int'(state_o), 0);

        $display("[TB] test5: external edge, abort mid-POST, arm+abort");
        setConfig(3, 0, 0, 0, 1, 8, 0);
        clearLog();
        ext_trig_i = 1'b1;
        arm_i = 1'b1;
        applyStimulus(0, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 6) ext_trig_i = 1'b0;
            if (k == 8) ext_trig_i = 1'b1;
            applyStimulus(k, 0);
        end
        checkOutput("t5_trig_idx", trigIdx, 7);
        checkOutput("t5_trig_addr", int'(trig_addr_o), 7);
        checkOutput("t5_state_post", int'(state_o), 3);
        abort_i = 1'b1;
        applyStimulus(11, 0);
        checkOutput("t5_abort_state", int'(state_o), 0);
        checkOutput("t5_abort_wr", int'(wr_en_o), 0);
        checkOutput("t5_abort_done", int'(done_o), 0);
        checkOutput("t5_abort_busy", int'(busy_o), 0);
        nBefore = nWrites;
        for (int k = 0; k < 4; k++) applyStimulus(k, 0);
        checkOutput("t5_no_writes", nWrites, nBefore);
        arm_i   = 1'b1;
        abort_i = 1'b1;
        applyStimulus(0, 0);
        checkOutput("t5_armabort_state", int'(state_o), 0);
        applyStimulus(0, 0);
        checkOutput("t5_armabort_wr", int'(wr_en_o), 0);
        checkOutput("t5_armabort_writes", nWrites, nBefore);
        ext_trig_i = 1'b0;

        $display("[TB] test6: async reset mid-POST");
        setConfig(0, 0, 0, 0, 1, 8, 0);
        clearLog();
        arm_i = 1'b1;
        applyStimulus(0, 0);
        for (int k = 1; k <= 3; k++) begin
            if (k == 2) sw_trig_i = 1'b1;
            applyStimulus(k, 5);
        end
        checkOutput("t6_state_post", int'(state_o), 3);
        checkOutput("t6_pre_rst_addr", int'(trig_addr_o), 1);
        #3;
        adc_rst_i = 1'b0;
        #1;
        checkOutput("t6_rst_wr_en", int'(wr_en_o), 0);
        checkOutput("t6_rst_state", int'(state_o), 0);
        checkOutput("t6_rst_wr_addr", int'(wr_addr_o), 0);
        checkOutput("t6_rst_wr_dat", int'(wr_dat_o), 0);
        checkOutput("t6_rst_trig_addr", int'(trig_addr_o), 0);
        checkOutput("t6_rst_busy", int'(busy_o), 0);
        repeat (2) @(posedge adc_clk);
        #1;
        adc_rst_i = 1'b1;
        clearLog();
        arm_i = 1'b1;
        applyStimulus(40, 0);
        applyStimulus(41, 0);
        applyStimulus(42, 0);
        checkOutput("t6_rearm_writes", nWrites, 2);
        checkOutput("t6_rearm_addr0", wrAddrLog[0], 0);
        checkOutput("t6_rearm_addr1", wrAddrLog[1], 1);
        checkOutput("t6_rearm_dat0", wrChaLog[0], 40);
        checkOutput("t6_rearm_state", int'(state_o), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
